// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider with signed/unsigned support.
// One quotient bit per cycle; flush-aware for pipeline exceptions.
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic             i_cancel,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state, state_nx;

   logic             accept;
   logic             neg_dvd;
   logic             neg_dvs;
   logic [WIDTH-1:0] dvd_raw;
   logic [WIDTH-1:0] dvs_raw;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign accept = (state == IDLE) && i_start && !i_cancel;
   assign rem_sh = {rem, acc_q[WIDTH-1]};
   assign ge     = rem_sh >= {1'b0, dvs_mag};
   assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs_mag})
                      : rem_sh[WIDTH-1:0];
   // Sign flags are only set in signed mode, so unsigned passes through.
   assign q_fix  = (neg_dvd ^ neg_dvs) ? -acc_q : acc_q;
   assign r_fix  = neg_dvd ? -rem : rem;

   assign o_busy = (state != IDLE) || accept;
   assign o_done = (state == DONE);

   // Next-state selection; a flush overrides every busy state.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = PREP;
         PREP: state_nx = (dvs_raw == '0) ? DONE : CALC;
         CALC: if (cnt == CW'(1)) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (state != IDLE && i_cancel) state_nx = IDLE;
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Operand capture and the shift/subtract datapath.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         neg_dvd <= 1'b0;
         neg_dvs <= 1'b0;
         dvd_raw <= '0;
         dvs_raw <= '0;
         acc_q   <= '0;
         dvs_mag <= '0;
         rem     <= '0;
         cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               dvd_raw <= i_dividend;
               dvs_raw <= i_divisor;
               neg_dvd <= i_signed & i_dividend[WIDTH-1];
               neg_dvs <= i_signed & i_divisor[WIDTH-1];
            end
            PREP: begin
               acc_q   <= neg_dvd ? -dvd_raw : dvd_raw;
               dvs_mag <= neg_dvs ? -dvs_raw : dvs_raw;
               rem     <= '0;
               cnt     <= CW'(WIDTH);
            end
            CALC: begin
               rem   <= rem_nx;
               acc_q <= {acc_q[WIDTH-2:0], ge};
               cnt   <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result registers load only on the way into DONE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_div_by_zero <= 1'b0;
      end else if (state_nx == DONE) begin
         if (state == PREP) begin
            o_quotient    <= '1;
            o_remainder   <= dvd_raw;
            o_div_by_zero <= 1'b1;
         end else begin
            o_quotient    <= q_fix;
            o_remainder   <= r_fix;
            o_div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 i_start  input  1  request a divide; sampled only in IDLE.
REQ-005 i_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with i_start.
REQ-006 i_dividend  input  WIDTH  dividend; sampled with i_start.
REQ-007 i_divisor  input  WIDTH  divisor; sampled with i_start.
REQ-008 i_cancel  input  1  exception flush; aborts any operation in progress.
REQ-009 o_busy  output  1  high while an operation occupies the unit; feeds the pipeline stall controller.
REQ-010 o_done  output  1  one-cycle pulse; results valid in that cycle.
REQ-011 o_quotient  output  WIDTH  quotient register.
REQ-012 o_remainder  output  WIDTH  remainder register.
REQ-013 o_div_by_zero  output  1  set with o_done when the sampled divisor was zero.

Function
REQ-014 The FSM SHALL have states IDLE, PREP, CALC, FIX and DONE.
REQ-015 IDLE -> PREP when i_start=1 and i_cancel=0; the block SHALL capture operands, i_signed, and the operand signs.
REQ-016 PREP, one cycle: SHALL load the dividend magnitude and divisor magnitude into working registers (signed mode: negate negative operands), clear the partial remainder, and load the iteration counter with WIDTH.
REQ-017 PREP with a zero divisor -> DONE: quotient = all ones, remainder = raw dividend, o_div_by_zero = 1.
REQ-018 PREP with a nonzero divisor -> CALC.
REQ-019 CALC SHALL perform one restoring-division step per cycle (shift remainder/dividend left 1, trial subtract, set quotient bit on non-negative result); it SHALL run exactly WIDTH cycles, then -> FIX.
REQ-020 FIX, one cycle: in signed mode, negate the quotient if the operand signs differ and negate the remainder if the dividend was negative; in unsigned mode, results pass through unchanged; -> DONE.
REQ-021 DONE, one cycle: o_done = 1, and o_quotient, o_remainder and o_div_by_zero are updated; -> IDLE.
REQ-022 Latency: with i_start sampled at edge N, o_done SHALL be high in cycle N+WIDTH+3 (normal path) or N+2 (divide by zero).
REQ-023 o_busy SHALL be high in every state except IDLE, and SHALL also be high combinationally in the IDLE cycle in which i_start is accepted.
REQ-024 Signed overflow (most negative value / -1) SHALL yield quotient = most negative value and remainder = 0, with no flag.
REQ-025 i_start outside IDLE SHALL be ignored, with no queuing.
REQ-026 i_cancel=1 in any non-IDLE state SHALL force IDLE at the next edge: no o_done, and the result outputs keep their previous values.
REQ-027 If i_cancel and i_start are both high in IDLE, cancel SHALL win and the start is dropped.
REQ-028 The result outputs SHALL hold their values until the next DONE.

Reset
REQ-029 resetn=0 SHALL immediately force state IDLE, o_busy=0 (absent i_start), o_done=0, o_quotient=0, o_remainder=0, o_div_by_zero=0, and clear all working registers and the counter.
REQ-030 Reset mid-operation SHALL discard the operation; the first accepted i_start after release SHALL behave as from a cold reset.

Verification
REQ-031 Unsigned 100/7, start at cycle 0 -> o_busy high in cycles 0-35, o_done in cycle 35, q=14, r=2.
REQ-032 Signed -7/2 (0xFFFFFFF9 / 0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
REQ-033 Divisor 0, dividend 0x1234 -> o_done at cycle 2, q=0xFFFFFFFF, r=0x1234, o_div_by_zero=1; next normal divide clears the flag.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, o_div_by_zero=0.
REQ-035 i_cancel at cycle 10 of a divide -> o_busy low from cycle 11, no o_done pulse, outputs unchanged; a new start at cycle 12 completes correctly.
REQ-036 resetn low at cycle 20 of a divide -> all outputs zero immediately; i_start pulses during busy are ignored, and only one o_done occurs per accepted start.
